reg_issue_ctrl: RTL and testbench

- Single-issue rename/issue sequencer in front of the architectural register file.
- Accepts decoded instructions from the decoder through a valid/ready handshake and holds one in a one-entry buffer.
- Drives the register file's two read-port IDs and the rename (issue) port, and fires issue only when the ROB and RS both have space.
- Blocks issue during ROB clear-up recovery, and keeps a performance counter of issued instructions.

---
 rtl/reg_issue_ctrl_pkg.sv | 29 ++
 rtl/issue_skid_buf.sv | 41 ++++
 rtl/reg_issue_ctrl.sv | 89 ++++++++
 tb/tb_reg_issue_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_issue_ctrl_pkg.sv
// Shared types and constants for the rename/issue sequencer.
// Holds the ROB index width, the FSM encoding and the buffered instruction payload.
package reg_issue_ctrl_pkg;

    localparam int unsigned ROB_BIT_DEF = 5;
    localparam int unsigned REG_W       = 5;
    localparam int unsigned CNT_W       = 32;
    localparam int unsigned FLUSH_W     = 4;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic             use_rs1;
        logic             use_rs2;
        logic             wr_rd;
    } dec_inst_t;

    // Unused sources read x0 so they never look like a dependency.
    function automatic logic [REG_W-1:0] src_id(input logic en, input logic [REG_W-1:0] id);
        return en ? id : '0;
    endfunction

endpackage

// File: rtl/issue_skid_buf.sv
// One-entry instruction buffer with decoder handshake and issue-fire qualification.
// Accept and issue can happen in the same cycle, sustaining one instruction per cycle.
module issue_skid_buf
    import reg_issue_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rdy,
    input  logic      run,
    input  logic      flush,
    input  logic      stall,
    input  logic      in_valid,
    input  dec_inst_t in_data,
    output logic      in_ready,
    output dec_inst_t buf_data,
    output logic      fire
);

    logic buf_valid;

    assign fire     = rdy & run & buf_valid & ~stall & ~flush;
    assign in_ready = rst_n & rdy & run & ~flush & (~buf_valid | fire);

    // Flush drops the held entry; otherwise accept refills and fire drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            buf_data  <= '0;
        end else if (rdy) begin
            if (flush) begin
                buf_valid <= 1'b0;
            end else if (in_valid && in_ready) begin
                buf_valid <= 1'b1;
                buf_data  <= in_data;
            end else if (fire) begin
                buf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/reg_issue_ctrl.sv
// Single-issue rename/issue sequencer in front of the architectural register file.
// Owns the recovery FSM, the flush countdown and the issued-instruction counter.
module reg_issue_ctrl
    import reg_issue_ctrl_pkg::*;
#(
    parameter int unsigned ROB_BIT      = ROB_BIT_DEF,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               rob_clear_up,
    input  logic               dec_valid,
    output logic               dec_ready,
    input  logic [REG_W-1:0]   dec_rd,
    input  logic [REG_W-1:0]   dec_rs1,
    input  logic [REG_W-1:0]   dec_rs2,
    input  logic               dec_use_rs1,
    input  logic               dec_use_rs2,
    input  logic               dec_wr_rd,
    input  logic               rob_full,
    input  logic [ROB_BIT-1:0] rob_tail,
    input  logic               rs_full,
    output logic [REG_W-1:0]   get_id1,
    output logic [REG_W-1:0]   get_id2,
    output logic               rob_issue_reg,
    output logic [REG_W-1:0]   issue_reg_id,
    output logic [ROB_BIT-1:0] issue_rob_entry,
    output logic               issue_valid,
    output logic [CNT_W-1:0]   issued_cnt
);

    state_t             state;
    logic [FLUSH_W-1:0] flush_cnt;
    dec_inst_t          dec_inst;
    dec_inst_t          buf_inst;
    logic               issue_fire;
    logic               run;

    assign dec_inst = {dec_rd, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2, dec_wr_rd};
    assign run      = (state == ST_RUN);

    issue_skid_buf u_buf (
        .clk      (clk_in),
        .rst_n    (rst_in),
        .rdy      (rdy_in),
        .run      (run),
        .flush    (rob_clear_up),
        .stall    (rob_full | rs_full),
        .in_valid (dec_valid),
        .in_data  (dec_inst),
        .in_ready (dec_ready),
        .buf_data (buf_inst),
        .fire     (issue_fire)
    );

    // Writes to x0 still issue but never rename.
    assign issue_valid     = issue_fire;
    assign rob_issue_reg   = issue_fire & buf_inst.wr_rd & (buf_inst.rd != '0);
    assign issue_reg_id    = rob_issue_reg ? buf_inst.rd : '0;
    assign issue_rob_entry = rst_in ? rob_tail : '0;
    assign get_id1         = src_id(buf_inst.use_rs1, buf_inst.rs1);
    assign get_id2         = src_id(buf_inst.use_rs2, buf_inst.rs2);

    // Recovery FSM and perf counter; everything holds while rdy_in is low.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state      <= ST_RUN;
            flush_cnt  <= '0;
            issued_cnt <= '0;
        end else if (rdy_in) begin
            if (issue_fire) begin
                issued_cnt <= issued_cnt + CNT_W'(1);
            end
            if (rob_clear_up) begin
                state     <= ST_FLUSH;
                flush_cnt <= FLUSH_W'(FLUSH_CYCLES);
            end else if (state == ST_FLUSH) begin
                if (flush_cnt <= FLUSH_W'(1)) begin
                    state     <= ST_RUN;
                    flush_cnt <= '0;
                end else begin
                    flush_cnt <= flush_cnt - FLUSH_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_issue_ctrl.sv
// Directed, table-driven bench for reg_issue_ctrl with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
module tb_reg_issue_ctrl;
    import reg_issue_ctrl_pkg::*;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             rdy_in;
    logic             rob_clear_up;
    logic             dec_valid;
    logic             dec_ready;
    logic [4:0]       dec_rd, dec_rs1, dec_rs2;
    logic             dec_use_rs1, dec_use_rs2, dec_wr_rd;
    logic             rob_full;
    logic [4:0]       rob_tail;
    logic             rs_full;
    logic [4:0]       get_id1, get_id2;
    logic             rob_issue_reg;
    logic [4:0]       issue_reg_id;
    logic [4:0]       issue_rob_entry;
    logic             issue_valid;
    logic [31:0]      issued_cnt;

    int n_checks = 0;
    int n_errors = 0;

    reg_issue_ctrl #(.ROB_BIT(5), .FLUSH_CYCLES(1)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .rob_clear_up    (rob_clear_up),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_rd          (dec_rd),
        .dec_rs1         (dec_rs1),
        .dec_rs2         (dec_rs2),
        .dec_use_rs1     (dec_use_rs1),
        .dec_use_rs2     (dec_use_rs2),
        .dec_wr_rd       (dec_wr_rd),
        .rob_full        (rob_full),
        .rob_tail        (rob_tail),
        .rs_full         (rs_full),
        .get_id1         (get_id1),
        .get_id2         (get_id2),
        .rob_issue_reg   (rob_issue_reg),
        .issue_reg_id    (issue_reg_id),
        .issue_rob_entry (issue_rob_entry),
        .issue_valid     (issue_valid),
        .issued_cnt      (issued_cnt)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic        rdy;
        logic        clr;
        logic        dv;
        dec_inst_t   inst;
        logic        rf;
        logic        sf;
        logic [4:0]  tail;
        logic        e_ready;
        logic        e_valid;
        logic        e_reg;
        logic [4:0]  e_id;
        logic [4:0]  e_g1;
        logic [4:0]  e_g2;
        logic [4:0]  e_entry;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic dec_inst_t ins(input int rd, input int rs1, input int rs2,
                                      input bit u1, input bit u2, input bit wr);
        dec_inst_t d;
        d.rd = 5'(rd); d.rs1 = 5'(rs1); d.rs2 = 5'(rs2);
        d.use_rs1 = u1; d.use_rs2 = u2; d.wr_rd = wr;
        return d;
    endfunction

    function automatic vec_t mk(input bit rdy, input bit clr, input bit dv, input dec_inst_t inst,
                                input bit rf, input bit sf, input int tail,
                                input bit e_ready, input bit e_valid, input bit e_reg, input int e_id,
                                input int e_g1, input int e_g2, input int e_entry, input int e_cnt);
        vec_t v;
        v.rdy = rdy; v.clr = clr; v.dv = dv; v.inst = inst; v.rf = rf; v.sf = sf;
        v.tail = 5'(tail); v.e_ready = e_ready; v.e_valid = e_valid; v.e_reg = e_reg;
        v.e_id = 5'(e_id); v.e_g1 = 5'(e_g1); v.e_g2 = 5'(e_g2);
        v.e_entry = 5'(e_entry); v.e_cnt = 32'(e_cnt);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rdy_in = v.rdy; rob_clear_up = v.clr; dec_valid = v.dv;
        dec_rd = v.inst.rd; dec_rs1 = v.inst.rs1; dec_rs2 = v.inst.rs2;
        dec_use_rs1 = v.inst.use_rs1; dec_use_rs2 = v.inst.use_rs2; dec_wr_rd = v.inst.wr_rd;
        rob_full = v.rf; rs_full = v.sf; rob_tail = v.tail;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk($sformatf("v%0d dec_ready", i),       32'(dec_ready),       32'(v.e_ready));
        chk($sformatf("v%0d issue_valid", i),     32'(issue_valid),     32'(v.e_valid));
        chk($sformatf("v%0d rob_issue_reg", i),   32'(rob_issue_reg),   32'(v.e_reg));
        chk($sformatf("v%0d issue_reg_id", i),    32'(issue_reg_id),    32'(v.e_id));
        chk($sformatf("v%0d get_id1", i),         32'(get_id1),         32'(v.e_g1));
        chk($sformatf("v%0d get_id2", i),         32'(get_id2),         32'(v.e_g2));
        chk($sformatf("v%0d issue_rob_entry", i), 32'(issue_rob_entry), 32'(v.e_entry));
        chk($sformatf("v%0d issued_cnt", i),      issued_cnt,           v.e_cnt);
    endtask

    initial begin
        dec_inst_t z, i0, i1, i2, i3, i4, i5, i6, i7, i8, i9;
        z  = ins(0, 0, 0, 0, 0, 0);
        i0 = ins(3, 1, 2, 1, 1, 1);
        i1 = ins(4, 5, 6, 1, 1, 1);
        i2 = ins(7, 4, 0, 1, 0, 1);
        i3 = ins(9, 10, 11, 0, 1, 0);
        i4 = ins(12, 13, 14, 1, 1, 1);
        i5 = ins(15, 16, 17, 1, 1, 1);
        i6 = ins(20, 21, 22, 1, 1, 1);
        i7 = ins(1, 2, 3, 1, 1, 1);
        i8 = ins(0, 5, 5, 1, 0, 1);
        i9 = ins(31, 31, 30, 1, 1, 1);

        //          rdy clr dv inst rf sf tail | rdy val reg id g1 g2 ent cnt
        // first instruction: accept then issue
        vecs.push_back(mk(1, 0, 0, z,  0, 0, 7,   1, 0, 0, 0,  0,  0,  7, 0));
        vecs.push_back(mk(1, 0, 1, i0, 0, 0, 7,   1, 0, 0, 0,  0,  0,  7, 0));
        vecs.push_back(mk(1, 0, 0, z,  0, 0, 7,   1, 1, 1, 3,  1,  2,  7, 0));
        // back-to-back stream of four
        vecs.push_back(mk(1, 0, 1, i1, 0, 0, 8,   1, 0, 0, 0,  1,  2,  8, 1));
        vecs.push_back(mk(1, 0, 1, i2, 0, 0, 9,   1, 1, 1, 4,  5,  6,  9, 1));
        vecs.push_back(mk(1, 0, 1, i3, 0, 0, 10,  1, 1, 1, 7,  4,  0, 10, 2));
        vecs.push_back(mk(1, 0, 1, i4, 0, 0, 11,  1, 1, 0, 0,  0, 11, 11, 3));
        vecs.push_back(mk(1, 0, 0, z,  0, 0, 12,  1, 1, 1, 12, 13, 14, 12, 4));
        // rob_full hold for three cycles, released with pass-through
        vecs.push_back(mk(1, 0, 1, i5, 0, 0, 13,  1, 0, 0, 0, 13, 14, 13, 5));
        vecs.push_back(mk(1, 0, 1, i6, 1, 0, 13,  0, 0, 0, 0, 16, 17, 13, 5));
        vecs.push_back(mk(1, 0, 1, i6, 1, 0, 13,  0, 0, 0, 0, 16, 17, 13, 5));
        vecs.push_back(mk(1, 0, 1, i6, 1, 0, 13,  0, 0, 0, 0, 16, 17, 13, 5));
        vecs.push_back(mk(1, 0, 1, i6, 0, 0, 14,  1, 1, 1, 15, 16, 17, 14, 5));
        // rs_full hold, then clear-up drops the held entry
        vecs.push_back(mk(1, 0, 0, z,  0, 1, 14,  0, 0, 0, 0, 21, 22, 14, 6));
        vecs.push_back(mk(1, 1, 1, i7, 0, 0, 14,  0, 0, 0, 0, 21, 22, 14, 6));
        vecs.push_back(mk(1, 0, 1, i7, 0, 0, 14,  0, 0, 0, 0, 21, 22, 14, 6));
        vecs.push_back(mk(1, 0, 1, i7, 0, 0, 14,  1, 0, 0, 0, 21, 22, 14, 6));
        // rdy low freezes state and ignores clear-up
        vecs.push_back(mk(0, 1, 1, i8, 0, 0, 15,  0, 0, 0, 0,  2,  3, 15, 6));
        vecs.push_back(mk(0, 0, 1, i8, 0, 0, 15,  0, 0, 0, 0,  2,  3, 15, 6));
        vecs.push_back(mk(1, 0, 1, i8, 0, 0, 16,  1, 1, 1, 1,  2,  3, 16, 6));
        // write to x0 issues without renaming
        vecs.push_back(mk(1, 0, 0, z,  0, 0, 17,  1, 1, 0, 0,  5,  0, 17, 7));
        // clear-up repeated during flush reloads the countdown
        vecs.push_back(mk(1, 1, 0, z,  0, 0, 0,   0, 0, 0, 0,  5,  0,  0, 8));
        vecs.push_back(mk(1, 1, 0, z,  0, 0, 0,   0, 0, 0, 0,  5,  0,  0, 8));
        vecs.push_back(mk(1, 0, 1, i9, 0, 0, 0,   0, 0, 0, 0,  5,  0,  0, 8));
        vecs.push_back(mk(1, 0, 1, i9, 0, 0, 0,   1, 0, 0, 0,  5,  0,  0, 8));
        vecs.push_back(mk(1, 0, 0, z,  0, 0, 31,  1, 1, 1, 31, 31, 30, 31, 8));
        vecs.push_back(mk(1, 0, 0, z,  0, 0, 31,  1, 0, 0, 0, 31, 30, 31, 9));

        // Reset with busy inputs: every output must read zero.
        rst_in = 1'b0;
        drive(mk(1, 0, 1, i0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0));
        #3;
        chk("reset dec_ready",       32'(dec_ready),       32'd0);
        chk("reset issue_valid",     32'(issue_valid),     32'd0);
        chk("reset rob_issue_reg",   32'(rob_issue_reg),   32'd0);
        chk("reset get_id1",         32'(get_id1),         32'd0);
        chk("reset get_id2",         32'(get_id2),         32'd0);
        chk("reset issue_rob_entry", 32'(issue_rob_entry), 32'd0);
        chk("reset issued_cnt",      issued_cnt,           32'd0);
        @(posedge clk_in); #1;
        rst_in = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            #3;
            check_vec(i, vecs[i]);
            @(posedge clk_in); #1;
        end

        // Asynchronous reset mid-run drops the buffer and clears the counter.
        drive(mk(1, 0, 1, i0, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk_in); #1;
        drive(mk(1, 0, 0, z, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0));
        #1 rst_in = 1'b0;
        #1;
        chk("async rst issue_valid", 32'(issue_valid),     32'd0);
        chk("async rst dec_ready",   32'(dec_ready),       32'd0);
        chk("async rst get_id1",     32'(get_id1),         32'd0);
        chk("async rst entry",       32'(issue_rob_entry), 32'd0);
        chk("async rst issued_cnt",  issued_cnt,           32'd0);
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        #2;
        chk("post rst dec_ready",    32'(dec_ready),       32'd1);
        chk("post rst issue_valid",  32'(issue_valid),     32'd0);
        chk("post rst entry",        32'(issue_rob_entry), 32'd4);
        @(posedge clk_in); #1;
        chk("post rst issued_cnt",   issued_cnt,           32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
